reorder_buffer: RTL and testbench
=================================

# reorder_buffer

16-entry circular reorder buffer between the decoder/issue stage and the register file. Allocates entries in program order, collects results from two writeback ports, and retires at most one entry per cycle from the head. Drives the register file's commit port (`commit_config`, `rs_to_write_id`, `rs_to_write_val`, `commit_rob_id`) and raises `rollback_config` on a mispredicted branch. Answers operand-readiness queries for the two ROB tags the register file returns as dirty.

## Interface
- `ROB_DEPTH`, default 16: number of entries; fixed by the 4-bit ROB id.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state.
- `alloc_valid` in 1: decoder requests an entry.
- `alloc_type` in 2: entry type; 0 = REG, 1 = BRANCH, 2 = STORE.
- `alloc_rd` in 5: destination register.
- `alloc_pred_taken` in 1: predicted direction, BRANCH only.
- `alloc_id` out 4: tail id assigned to the current request.
- `full` out 1: all 16 entries valid.
- `wb0_valid`/`wb1_valid` in 1: ALU / LSB writeback strobes.
- `wb0_id`/`wb1_id` in 4: target entry.
- `wb0_val`/`wb1_val` in 32: result value.
- `wb0_taken` in 1: actual branch direction.
- `wb0_target` in 32: correct next PC.
- `q1_id`/`q2_id` in 4: query tags.
- `q1_ready`/`q2_ready` out 1: tagged entry has its value.
- `q1_val`/`q2_val` out 32: that value.
- `commit_config` out 1, `rs_to_write_id` out 5, `rs_to_write_val` out 32, `commit_rob_id` out 4: register commit.
- `store_commit` out 1: head STORE retired; `commit_rob_id` identifies it.
- `rollback_config` out 1, `rollback_pc` out 32: flush request and redirect PC.

## Operation
- State: `head`, `tail` (4-bit, wrap 15→0) and `count` (5-bit). Each entry holds valid, ready, type, rd, pred_taken, taken, val, target.
- `full` = (`count` == 16). `alloc_id` = `tail`, combinational.
- Allocation is accepted when `alloc_valid` && !`full` && !`rollback_config`. The entry is written valid with ready=0, and `tail` increments.
- A writeback sets ready and stores val/taken/target in the addressed entry. Both ports may write in the same cycle, always to different ids. A writeback to an invalid entry is ignored.
- Commit occurs when the head entry is valid && ready. `head` increments and the entry is cleared.
  - REG: `commit_config`=1, `rs_to_write_id`=rd (rd=0 still asserts), `rs_to_write_val`=val.
  - STORE: `store_commit`=1.
  - BRANCH, taken == pred_taken: retire only; if rd≠0 (JAL/JALR link), also do the REG write.
  - BRANCH, mispredicted: `rollback_config`=1 and `rollback_pc`=target, plus the link write if rd≠0.
- Rollback: on the edge that registers `rollback_config`, all entries are invalidated and `head`=`tail`=`count`=0. Allocations and writebacks on that edge are dropped.
- Query: ready/val come from entry `q*_id`. If `wb0_id` or `wb1_id` matches in the same cycle with valid asserted, the writeback value is bypassed combinationally with ready=1.
- Simultaneous allocate and commit leaves `count` unchanged. Allocate is allowed on the same edge the buffer stops being full only if `full` was low at the start of the cycle.

## Timing
- Reset (`rst`=0, asynchronous): all pointers, counts and entry valid/ready bits are 0. Every output is 0, `full`=0, `alloc_id`=0.
- All commit/store/rollback outputs are registered one-cycle pulses.
- A writeback at edge N makes the entry ready. If it is the head, the commit outputs go high after edge N+1, and the register file samples them at edge N+2.
- Minimum allocate-to-commit latency is 2 edges after the writeback edge.
- `rdy`=0 at an edge: no state change, and all pulse outputs register 0.
- A reset asserted mid-operation clears everything immediately; there is no pending commit afterwards.
- Throughput: 1 allocation and 1 commit per cycle.

## Structure
- Shared defines header (guarded with `ifndef`): ROB depth 16, ROB id width 4, entry-type encodings REG/BRANCH/STORE.
- One combinational sub-module `rob_query_port`, instantiated twice: entry read plus two-port writeback bypass.

## Test plan
- Reset: after `rst` low then high, `full`=0, `alloc_id`=0, `commit_config`=0.
- REG flow: allocate rd=5 (id 0), then wb0 id 0 val 0x1234 → one cycle later `commit_config`=1, `rs_to_write_id`=5, `rs_to_write_val`=0x1234, `commit_rob_id`=0.
- Full/wrap: 16 allocations → `full`=1 and a 17th is ignored. Commit one, allocate one → new `alloc_id`=0 (wrapped).
- Out-of-order writeback: write id 1 before id 0 → no commit until id 0 is written, then commits 0 and 1 on consecutive cycles.
- Mispredict: BRANCH pred_taken=0, wb0 taken=1 target 0x100 → `rollback_config`=1, `rollback_pc`=0x100. The next cycle shows `count`=0, and allocation during the rollback pulse is ignored.
- Query bypass: `q1_id`=3 with `wb1_id`=3 val 0xAA in the same cycle → `q1_ready`=1, `q1_val`=0xAA combinationally.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB sizing, entry-type encodings and entry layout.
`ifndef REORDER_BUFFER_PKG_SV
`define REORDER_BUFFER_PKG_SV
package reorder_buffer_pkg;
  localparam int ROB_N = 16;
  localparam int ROB_IDW = 4;
  typedef enum logic [1:0] {T_REG = 2'd0, T_BRANCH = 2'd1, T_STORE = 2'd2} rob_type_t;
  typedef struct packed {
    logic        valid;
    logic        ready;
    rob_type_t   typ;
    logic [4:0]  rd;
    logic        pred_taken;
    logic        taken;
    logic [31:0] val;
    logic [31:0] target;
  } rob_entry_t;
endpackage
`endif

// File: rtl/reorder_buffer_query.sv
// rob_query_port: operand readiness lookup with same-cycle writeback bypass.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_N
) (
  input  logic [ROB_IDW-1:0]     q_id,
  input  logic [DEPTH-1:0]       ready_vec,
  input  logic [DEPTH-1:0][31:0] val_vec,
  input  logic                   wb0_valid,
  input  logic [ROB_IDW-1:0]     wb0_id,
  input  logic [31:0]            wb0_val,
  input  logic                   wb1_valid,
  input  logic [ROB_IDW-1:0]     wb1_id,
  input  logic [31:0]            wb1_val,
  output logic                   q_ready,
  output logic [31:0]            q_val
);
  logic hit0, hit1;
  assign hit0 = wb0_valid && wb0_id == q_id;
  assign hit1 = wb1_valid && wb1_id == q_id;
  assign q_ready = hit0 || hit1 || ready_vec[q_id];
  assign q_val = hit0 ? wb0_val : hit1 ? wb1_val : val_vec[q_id];
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order-retire ROB with two writeback ports and branch rollback.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               alloc_valid,
  input  logic [1:0]         alloc_type,
  input  logic [4:0]         alloc_rd,
  input  logic               alloc_pred_taken,
  output logic [ROB_IDW-1:0] alloc_id,
  output logic               full,
  input  logic               wb0_valid,
  input  logic [ROB_IDW-1:0] wb0_id,
  input  logic [31:0]        wb0_val,
  input  logic               wb0_taken,
  input  logic [31:0]        wb0_target,
  input  logic               wb1_valid,
  input  logic [ROB_IDW-1:0] wb1_id,
  input  logic [31:0]        wb1_val,
  input  logic [ROB_IDW-1:0] q1_id,
  input  logic [ROB_IDW-1:0] q2_id,
  output logic               q1_ready,
  output logic [31:0]        q1_val,
  output logic               q2_ready,
  output logic [31:0]        q2_val,
  output logic               commit_config,
  output logic [4:0]         rs_to_write_id,
  output logic [31:0]        rs_to_write_val,
  output logic [ROB_IDW-1:0] commit_rob_id,
  output logic               store_commit,
  output logic               rollback_config,
  output logic [31:0]        rollback_pc
);
  rob_entry_t rob [ROB_DEPTH];
  logic [ROB_IDW-1:0] head, tail;
  logic [ROB_IDW:0] count;
  rob_entry_t h;
  logic do_alloc, do_commit, mispredict, link;
  logic [ROB_DEPTH-1:0] ready_vec;
  logic [ROB_DEPTH-1:0][31:0] val_vec;
  assign full = count == (ROB_IDW+1)'(ROB_DEPTH);
  assign alloc_id = tail;
  assign h = rob[head];
  assign do_alloc = rdy && alloc_valid && !full && !rollback_config;
  assign do_commit = rdy && h.valid && h.ready;
  assign mispredict = h.typ == T_BRANCH && h.taken != h.pred_taken;
  assign link = h.typ == T_REG || (h.typ == T_BRANCH && h.rd != 5'd0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      commit_config <= 1'b0;
      rs_to_write_id <= '0;
      rs_to_write_val <= '0;
      commit_rob_id <= '0;
      store_commit <= 1'b0;
      rollback_config <= 1'b0;
      rollback_pc <= '0;
    end else begin
      commit_config <= do_commit && link;
      store_commit <= do_commit && h.typ == T_STORE;
      rollback_config <= do_commit && mispredict;
      if (do_commit) begin
        rs_to_write_id <= h.rd;
        rs_to_write_val <= h.val;
        commit_rob_id <= head;
      end
      if (do_commit && mispredict) rollback_pc <= h.target;
      // A mispredict retiring flushes everything younger, dropping this edge's alloc/writebacks.
      if (do_commit && mispredict) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          rob[i].valid <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else if (rdy) begin
        if (wb0_valid && rob[wb0_id].valid) begin
          rob[wb0_id].ready <= 1'b1;
          rob[wb0_id].val <= wb0_val;
          rob[wb0_id].taken <= wb0_taken;
          rob[wb0_id].target <= wb0_target;
        end
        if (wb1_valid && rob[wb1_id].valid) begin
          rob[wb1_id].ready <= 1'b1;
          rob[wb1_id].val <= wb1_val;
        end
        if (do_alloc) begin
          rob[tail] <= '{valid: 1'b1, ready: 1'b0, typ: rob_type_t'(alloc_type), rd: alloc_rd,
                         pred_taken: alloc_pred_taken, taken: 1'b0, val: '0, target: '0};
          tail <= tail + 1'b1;
        end
        if (do_commit) begin
          rob[head].valid <= 1'b0;
          rob[head].ready <= 1'b0;
          head <= head + 1'b1;
        end
        count <= count + {{ROB_IDW{1'b0}}, do_alloc} - {{ROB_IDW{1'b0}}, do_commit};
      end
    end
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_vec
    assign ready_vec[i] = rob[i].ready;
    assign val_vec[i] = rob[i].val;
  end
  rob_query_port #(.DEPTH(ROB_DEPTH)) u_q1 (
    .q_id(q1_id), .ready_vec(ready_vec), .val_vec(val_vec),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .q_ready(q1_ready), .q_val(q1_val)
  );
  rob_query_port #(.DEPTH(ROB_DEPTH)) u_q2 (
    .q_id(q2_id), .ready_vec(ready_vec), .val_vec(val_vec),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .q_ready(q2_ready), .q_val(q2_val)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer retire, rollback, query and full handling.
module tb_reorder_buffer;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic alloc_valid = 1'b0, alloc_pred_taken = 1'b0;
  logic [1:0] alloc_type = '0;
  logic [4:0] alloc_rd = '0;
  logic [3:0] alloc_id, wb0_id = '0, wb1_id = '0, q1_id = '0, q2_id = '0, commit_rob_id;
  logic full, wb0_valid = 1'b0, wb0_taken = 1'b0, wb1_valid = 1'b0;
  logic [31:0] wb0_val = '0, wb0_target = '0, wb1_val = '0, q1_val, q2_val;
  logic q1_ready, q2_ready, commit_config, store_commit, rollback_config;
  logic [4:0] rs_to_write_id;
  logic [31:0] rs_to_write_val, rollback_pc;
  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  id;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pred_taken(alloc_pred_taken), .alloc_id(alloc_id), .full(full),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val), .wb0_taken(wb0_taken),
    .wb0_target(wb0_target), .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q1_val(q1_val),
    .q2_ready(q2_ready), .q2_val(q2_val), .commit_config(commit_config),
    .rs_to_write_id(rs_to_write_id), .rs_to_write_val(rs_to_write_val),
    .commit_rob_id(commit_rob_id), .store_commit(store_commit),
    .rollback_config(rollback_config), .rollback_pc(rollback_pc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic pt);
    alloc_valid = 1'b1;
    alloc_type = t;
    alloc_rd = rd;
    alloc_pred_taken = pt;
  endtask
  // Every retire pulse must match the oldest outstanding expectation.
  always @(negedge clk)
    if (rst && (commit_config || store_commit || rollback_config)) begin
      if (sb.size() == 0)
        check("unexpected_retire", 32'({rollback_config, store_commit, commit_config}), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("retire_kind", 32'({rollback_config, store_commit, commit_config}), 32'(e.kind));
        check("retire_rob_id", 32'(commit_rob_id), 32'(e.id));
        if (e.kind[0]) begin
          check("retire_rd", 32'(rs_to_write_id), 32'(e.rd));
          check("retire_val", rs_to_write_val, e.val);
        end
        if (e.kind[2]) check("rollback_pc", rollback_pc, e.pc);
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    check("rst_full", 32'(full), 32'd0);
    check("rst_alloc_id", 32'(alloc_id), 32'd0);
    check("rst_commit", 32'(commit_config), 32'd0);
    rst = 1'b1;
    tick();
    // REG flow
    alloc(2'd0, 5'd5, 1'b0);
    check("reg_alloc_id", 32'(alloc_id), 32'd0);
    tick();
    alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h1234;
    sb.push_back('{3'b001, 5'd5, 32'h1234, 4'd0, 32'd0});
    tick();
    wb0_valid = 1'b0;
    check("reg_no_early_commit", 32'(commit_config), 32'd0);
    tick();
    check("reg_commit", 32'(commit_config), 32'd1);
    check("reg_rd", 32'(rs_to_write_id), 32'd5);
    check("reg_val", rs_to_write_val, 32'h1234);
    check("reg_rob_id", 32'(commit_rob_id), 32'd0);
    tick();
    check("reg_pulse_end", 32'(commit_config), 32'd0);
    // out-of-order writeback
    alloc(2'd0, 5'd7, 1'b0);
    tick();
    alloc(2'd0, 5'd8, 1'b0);
    tick();
    alloc_valid = 1'b0;
    wb1_valid = 1'b1; wb1_id = 4'd2; wb1_val = 32'h22;
    tick();
    wb1_valid = 1'b0;
    tick();
    tick();
    check("ooo_wait", 32'(commit_config), 32'd0);
    wb0_valid = 1'b1; wb0_id = 4'd1; wb0_val = 32'h11;
    sb.push_back('{3'b001, 5'd7, 32'h11, 4'd1, 32'd0});
    sb.push_back('{3'b001, 5'd8, 32'h22, 4'd2, 32'd0});
    tick();
    wb0_valid = 1'b0;
    tick();
    check("ooo_first_id", 32'(commit_rob_id), 32'd1);
    tick();
    check("ooo_second_id", 32'(commit_rob_id), 32'd2);
    check("ooo_second_commit", 32'(commit_config), 32'd1);
    tick();
    // STORE plus query bypass
    alloc(2'd2, 5'd0, 1'b0);
    check("store_alloc_id", 32'(alloc_id), 32'd3);
    tick();
    alloc_valid = 1'b0;
    q1_id = 4'd3;
    #1;
    check("q1_not_ready", 32'(q1_ready), 32'd0);
    wb1_valid = 1'b1; wb1_id = 4'd3; wb1_val = 32'hAA;
    #1;
    check("q1_bypass_ready", 32'(q1_ready), 32'd1);
    check("q1_bypass_val", q1_val, 32'hAA);
    sb.push_back('{3'b010, 5'd0, 32'd0, 4'd3, 32'd0});
    tick();
    wb1_valid = 1'b0;
    q2_id = 4'd3;
    #1;
    check("q2_stored_ready", 32'(q2_ready), 32'd1);
    check("q2_stored_val", q2_val, 32'hAA);
    tick();
    check("store_commit", 32'(store_commit), 32'd1);
    check("store_no_reg", 32'(commit_config), 32'd0);
    check("q2_cleared", 32'(q2_ready), 32'd0);
    tick();
    // correctly predicted branches: link and no-link
    alloc(2'd1, 5'd1, 1'b1);
    tick();
    alloc(2'd1, 5'd0, 1'b0);
    tick();
    alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_id = 4'd4; wb0_val = 32'h40; wb0_taken = 1'b1; wb0_target = 32'h44;
    sb.push_back('{3'b001, 5'd1, 32'h40, 4'd4, 32'd0});
    tick();
    wb0_id = 4'd5; wb0_val = 32'h0; wb0_taken = 1'b0; wb0_target = 32'h50;
    tick();
    wb0_valid = 1'b0;
    tick();
    tick();
    check("branch_nolink_quiet", 32'({rollback_config, commit_config}), 32'd0);
    // reset mid-operation drops a pending commit
    alloc(2'd0, 5'd6, 1'b0);
    tick();
    alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_id = 4'd6; wb0_val = 32'h66;
    tick();
    wb0_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_alloc_id", 32'(alloc_id), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    tick();
    check("midrst_commit", 32'(commit_config), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    check("midrst_no_pending", 32'(commit_config), 32'd0);
    // full and wrap
    for (int i = 0; i < 16; i++) begin
      alloc(2'd0, 5'(i + 1), 1'b0);
      check("fill_alloc_id", 32'(alloc_id), 32'(i));
      check("fill_not_full", 32'(full), 32'd0);
      tick();
    end
    alloc(2'd0, 5'd17, 1'b0);
    check("full_set", 32'(full), 32'd1);
    tick();
    check("full_17th_ignored", 32'(alloc_id), 32'd0);
    check("full_still", 32'(full), 32'd1);
    wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h500;
    sb.push_back('{3'b001, 5'd1, 32'h500, 4'd0, 32'd0});
    tick();
    wb0_valid = 1'b0;
    check("full_before_commit", 32'(full), 32'd1);
    tick();
    check("full_commit_edge_no_alloc", 32'(alloc_id), 32'd0);
    check("full_cleared", 32'(full), 32'd0);
    tick();
    check("wrap_alloc_taken", 32'(alloc_id), 32'd1);
    check("wrap_full_again", 32'(full), 32'd1);
    alloc_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    // mispredict flush; younger ready entry must never retire
    alloc(2'd1, 5'd0, 1'b0);
    tick();
    alloc(2'd0, 5'd9, 1'b0);
    tick();
    alloc_valid = 1'b0;
    wb1_valid = 1'b1; wb1_id = 4'd1; wb1_val = 32'h99;
    wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h0; wb0_taken = 1'b1; wb0_target = 32'h100;
    sb.push_back('{3'b100, 5'd0, 32'd0, 4'd0, 32'h100});
    tick();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    tick();
    check("rb_config", 32'(rollback_config), 32'd1);
    check("rb_pc", rollback_pc, 32'h100);
    check("rb_alloc_id", 32'(alloc_id), 32'd0);
    alloc(2'd0, 5'd3, 1'b0);
    tick();
    alloc_valid = 1'b0;
    check("rb_alloc_dropped", 32'(alloc_id), 32'd0);
    check("rb_pulse_end", 32'(rollback_config), 32'd0);
    tick();
    tick();
    // mispredict with link write
    alloc(2'd1, 5'd2, 1'b1);
    tick();
    alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'h204; wb0_taken = 1'b0; wb0_target = 32'h200;
    sb.push_back('{3'b101, 5'd2, 32'h204, 4'd0, 32'h200});
    tick();
    wb0_valid = 1'b0;
    tick();
    check("rblink_rollback", 32'(rollback_config), 32'd1);
    check("rblink_commit", 32'(commit_config), 32'd1);
    tick();
    // rdy freeze
    alloc(2'd0, 5'd4, 1'b0);
    tick();
    alloc_valid = 1'b0;
    wb0_valid = 1'b1; wb0_id = 4'd0; wb0_val = 32'hCAFE;
    tick();
    wb0_valid = 1'b0;
    rdy = 1'b0;
    alloc(2'd0, 5'd5, 1'b0);
    tick();
    tick();
    check("frz_no_commit", 32'(commit_config), 32'd0);
    check("frz_no_alloc", 32'(alloc_id), 32'd1);
    alloc_valid = 1'b0;
    rdy = 1'b1;
    sb.push_back('{3'b001, 5'd4, 32'hCAFE, 4'd0, 32'd0});
    tick();
    check("frz_release_commit", 32'(commit_config), 32'd1);
    check("frz_release_val", rs_to_write_val, 32'hCAFE);
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
